// File: rtl/alluvial_pkg.sv
// Shared types and constants for the alluvial ALU and its byte-stream command port.
package alluvial_pkg;

  typedef enum logic [7:0] {
    ADD = 8'd0
  } Op;

  typedef enum logic [2:0] {
    ST_RX_OP,
    ST_RX_A,
    ST_RX_B,
    ST_RX_CHK,
    ST_EXEC,
    ST_TX_STATUS,
    ST_TX_RESULT
  } state_t;

  localparam int STAT_ERR     = 0;
  localparam int STAT_ILLEGAL = 1;
  localparam int STAT_CHK     = 2;

endpackage

// File: rtl/alluvial_cmd_port.sv
// Command front end for alluvial: decodes op/a/b byte frames, drives the ALU and returns status+result.
// Optional check byte (opcode ^ a ^ b) enabled with ALLUVIAL_CMD_PARITY_EN.
module alluvial_cmd_port
  import alluvial_pkg::*;
#(
  parameter int OP_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  input  logic                alu_error,
  input  logic [7:0]          alu_result,
  output logic                busy
);

  state_t     state;
  state_t     state_nxt;
  logic       rx_state;
  logic       rx_fire;
  logic       illegal;
  logic       chk_fail;
  logic [7:0] status_byte;
  logic [7:0] result_byte;

  // rx_ready is gated by rst so no byte is lost into a frame that reset is about to discard
  assign rx_state = (state == ST_RX_OP) || (state == ST_RX_A) ||
                    (state == ST_RX_B)  || (state == ST_RX_CHK);
  assign rx_ready = rx_state && !rst;
  assign rx_fire  = rx_valid && rx_ready;
  assign busy     = (state != ST_RX_OP);

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      ST_RX_OP:  if (rx_fire) state_nxt = ST_RX_A;
      ST_RX_A:   if (rx_fire) state_nxt = ST_RX_B;
`ifdef ALLUVIAL_CMD_PARITY_EN
      ST_RX_B:   if (rx_fire) state_nxt = ST_RX_CHK;
`else
      ST_RX_B:   if (rx_fire) state_nxt = ST_EXEC;
`endif
      ST_RX_CHK: if (rx_fire) state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_TX_STATUS;
      ST_TX_STATUS: begin
        tx_valid = 1'b1;
        tx_data  = status_byte;
        if (tx_ready) state_nxt = ST_TX_RESULT;
      end
      ST_TX_RESULT: begin
        tx_valid = 1'b1;
        tx_data  = result_byte;
        if (tx_ready) state_nxt = ST_RX_OP;
      end
      default:   state_nxt = ST_RX_OP;
    endcase
  end

`ifdef ALLUVIAL_CMD_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_fail <= 1'b0;
    end else if (rx_fire && state == ST_RX_OP) begin
      chk_fail <= 1'b0;
    end else if (rx_fire && state == ST_RX_CHK) begin
      chk_fail <= (rx_data != (alu_op[7:0] ^ alu_a ^ alu_b));
    end
  end
`else
  assign chk_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RX_OP;
      alu_op      <= '0;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      illegal     <= 1'b0;
      status_byte <= 8'h00;
      result_byte <= 8'h00;
    end else begin
      state <= state_nxt;
      if (rx_fire) begin
        case (state)
          ST_RX_OP: begin
            alu_op  <= OP_WIDTH'(rx_data);
            illegal <= (rx_data != ADD);
          end
          ST_RX_A: alu_a <= rx_data;
          ST_RX_B: alu_b <= rx_data;
          default: ;
        endcase
      end
      // Response is frozen here; a failed check or illegal opcode masks whatever the ALU produced
      if (state == ST_EXEC) begin
        status_byte <= 8'h00;
        result_byte <= 8'h00;
        if (chk_fail) begin
          status_byte[STAT_CHK] <= 1'b1;
        end else if (illegal) begin
          status_byte[STAT_ILLEGAL] <= 1'b1;
        end else begin
          status_byte[STAT_ERR] <= alu_error;
          result_byte           <= alu_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_alluvial_cmd_port.sv
// Directed bench for alluvial_cmd_port with a behavioural 8-bit ADD ALU attached to the alu_* ports.
module tb_alluvial_cmd_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [31:0] alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_error;
  logic [7:0]  alu_result;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // ALU stand-in: 8-bit modulo add with carry on error
  assign {alu_error, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

  alluvial_cmd_port #(.OP_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_error(alu_error), .alu_result(alu_result),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rx_handshake", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    tx_ready = 1'b1;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, tx_valid, 1);
    chk(tag, tx_data, exp);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    send_byte(op);
    send_byte(a);
    send_byte(b);
`ifdef ALLUVIAL_CMD_PARITY_EN
    send_byte(op ^ a ^ b);
`endif
  endtask

  task automatic run_frame(input string tag, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] st, input logic [7:0] res);
    send_frame(op, a, b);
    @(negedge clk);
    chk({tag, "_exec_tx_valid"}, tx_valid, 0);
    chk({tag, "_exec_rx_ready"}, rx_ready, 0);
    @(negedge clk);
    chk({tag, "_lat_tx_valid"}, tx_valid, 1);
    recv_byte({tag, "_status"}, st);
    recv_byte({tag, "_result"}, res);
    @(negedge clk);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_rx_ready_done"}, rx_ready, 1);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rx_ready", rx_ready, 1);

    // Basic ADD
    send_byte(8'h00);
    @(negedge clk);
    chk("busy_mid_frame", busy, 1);
    send_byte(8'h12);
    send_byte(8'h34);
`ifdef ALLUVIAL_CMD_PARITY_EN
    send_byte(8'h26);
`endif
    chk("add_alu_op", alu_op, 0);
    chk("add_alu_a", alu_a, 8'h12);
    chk("add_alu_b", alu_b, 8'h34);
    recv_byte("add_status", 8'h00);
    chk("busy_between_tx", busy, 1);
    recv_byte("add_result", 8'h46);
    @(negedge clk);
    chk("add_busy_done", busy, 0);

    run_frame("carry", 8'h00, 8'hFF, 8'h01, 8'h01, 8'h00);

    run_frame("illegal", 8'h05, 8'hAA, 8'h55, 8'h02, 8'h00);
    chk("illegal_alu_op", alu_op, 32'h5);
    run_frame("after_illegal", 8'h00, 8'h01, 8'h01, 8'h00, 8'h02);

    // Sink stall; stray input bytes must not be consumed meanwhile
    send_frame(8'h00, 8'h10, 8'h20);
    repeat (2) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      chk("stall_tx_valid", tx_valid, 1);
      chk("stall_tx_data", tx_data, 8'h00);
      chk("stall_rx_ready", rx_ready, 0);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    recv_byte("stall_status", 8'h00);
    recv_byte("stall_result", 8'h30);

    // Mid-frame reset after opcode and a
    send_byte(8'h00);
    send_byte(8'h09);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rx_ready", rx_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_alu_op", alu_op, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_rx_ready_after", rx_ready, 1);
    run_frame("after_rst", 8'h00, 8'h03, 8'h04, 8'h00, 8'h07);

`ifdef ALLUVIAL_CMD_PARITY_EN
    // Bad check byte: 0x27 instead of 0x26
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h27);
    recv_byte("badchk_status", 8'h04);
    recv_byte("badchk_result", 8'h00);
    run_frame("after_badchk", 8'h00, 8'h12, 8'h34, 8'h00, 8'h46);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alluvial_cmd_port.md
# alluvial_cmd_port

Byte-stream command front end for the `alluvial` arithmetic unit. It receives framed command bytes (opcode, operand a, operand b) over a valid/ready input stream and decodes them. It drives the ALU's `op`/`a`/`b` inputs, samples `result`/`error`, and returns a two-byte response frame over a valid/ready output stream. It sits between a host byte link and an `alluvial` instance in the parent module, acting as the initiator to the ALU's responder.

## Interface
- `OP_WIDTH`, 32: width of the ALU opcode bus; the received opcode byte is zero-extended to this width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `rx_valid`  in  1  command byte available.
- `rx_data`  in  8  command byte.
- `rx_ready`  out  1  port accepts a command byte this cycle.
- `tx_valid`  out  1  response byte available.
- `tx_data`  out  8  response byte.
- `tx_ready`  in  1  sink accepts a response byte this cycle.
- `alu_op`  out  OP_WIDTH  to ALU `op`.
- `alu_a`, `alu_b`  out  8  to ALU operands.
- `alu_error`  in  1  from ALU `error` (carry out for ADD).
- `alu_result`  in  8  from ALU `result`.
- `busy`  out  1  high from first accepted byte of a frame until the last response byte is accepted.

## Operation
- FSM states: RX_OP, RX_A, RX_B, (RX_CHK with parity), EXEC, TX_STATUS, TX_RESULT.
- A byte transfers when valid and ready are both high on a rising edge.
- RX_OP: opcode byte captured into `alu_op` (zero-extended). RX_A: captured into `alu_a`. RX_B: captured into `alu_b`. Each accepted byte advances the FSM by one state.
- Legal opcodes: 0 = ADD. Any other value sets the illegal flag; the frame is still fully consumed.
- EXEC: one cycle; samples `alu_error` and `alu_result` into response registers. For an illegal opcode the sampled result is forced to 0x00 and the error bit to 0.
- Status byte: bit0 = ALU error, bit1 = illegal opcode, bit2 = checksum fail (with parity, else 0), bits 7:3 = 0.
- TX_STATUS sends the status byte, then TX_RESULT sends the result byte, then the FSM returns to RX_OP.
- `rx_ready` = 1 only in RX_* states and only while `rst` is low. `tx_valid` = 1 only in TX_* states.
- `alu_op`/`alu_a`/`alu_b` hold their last captured values until overwritten by the next frame.

## Timing
- Reset values: state RX_OP; `rx_ready` 0 during reset cycles, 1 the first cycle after; `tx_valid` 0, `tx_data` 0x00, `busy` 0, `alu_op` 0, `alu_a` 0, `alu_b` 0.
- Latency: last command byte accepted at edge N → EXEC during cycle N+1 → `tx_valid` high with status at cycle N+2.
- Minimum frame period: 3 rx + 1 exec + 2 tx = 6 cycles (7 with parity).
- `tx_valid`/`tx_data` stay stable while `tx_ready` is low. There is no timeout.
- No overlap between frames: `rx_ready` stays low through EXEC and TX_*. Input bytes arriving then are not consumed.
- `rst` at any state, including mid-frame or mid-response, aborts the frame and discards partial bytes and pending response. The next accepted byte is treated as an opcode.
- Width rule: ADD is 8-bit modulo; carry is reported only via status bit0.

## Configuration
- `ALLUVIAL_CMD_PARITY_EN` defined: the frame gains a 4th byte (RX_CHK), which must equal opcode XOR a XOR b.
  - On mismatch: status bit2 = 1, result = 0x00, bit0 = bit1 = 0, and the ALU output is ignored.
- Undefined: 3-byte frames, no RX_CHK state, and bit2 always 0.

## Structure
- `alluvial_pkg` holds:
  - the `Op` enum (ADD = 0), shared with `alluvial`;
  - the state enum;
  - the status bit-index constants (`STAT_ERR` = 0, `STAT_ILLEGAL` = 1, `STAT_CHK` = 2).
- No sub-module: the `alluvial` instance lives in the parent, wired to the `alu_*` ports.

## Test plan
- Frame 0x00, 0x12, 0x34 → response 0x00, 0x46; `alu_op` = 0, `busy` drops after the second tx byte.
- Frame 0x00, 0xFF, 0x01 → response 0x01, 0x00 (carry reported).
- Frame 0x05, 0xAA, 0x55 → response 0x02, 0x00; the next frame 0x00, 0x01, 0x01 returns 0x00, 0x02.
- `tx_ready` held low for 5 cycles after the ADD 0x10 + 0x20 frame → `tx_data` held at 0x00 throughout, `rx_ready` = 0. Response 0x00, 0x30 then completes.
- `rst` pulsed for 1 cycle after opcode and a are accepted → all outputs return to reset values. Frame 0x00, 0x03, 0x04 then returns 0x00, 0x07.
- With `ALLUVIAL_CMD_PARITY_EN`: frame 0x00, 0x12, 0x34, 0x26 → 0x00, 0x46. The same frame with check byte 0x27 → 0x04, 0x00.
